vector_add_issue: RTL and testbench
===================================

# vector_add_issue

Operand-pairing and issue stage directly upstream of the 16-lane fp32 `vector_add` unit in the MM datapath. It buffers two independent 512-bit operand streams, pairs them head-to-head, and issues each pair to the adder. It captures the adder's fixed-latency results in an output FIFO, with credit-based flow control, because the adder has no backpressure. Downstream consumers see a standard valid/ready result stream.

## Interface
- `DATA_WIDTH`, 512, operand/result width (16 × fp32)
- `IN_DEPTH`, 4, per-operand input FIFO depth, power of 2, ≥2
- `OUT_DEPTH`, 16, result FIFO depth and initial credit count, power of 2, ≥ adder latency + 2
- `clk` in 1: single clock; all logic rising-edge
- `rst` in 1: synchronous, active-high reset
- `a_valid` in 1 / `a_ready` out 1 / `a_data` in DATA_WIDTH: operand-1 stream
- `b_valid` in 1 / `b_ready` out 1 / `b_data` in DATA_WIDTH: operand-2 stream
- `add_vector_1` out DATA_WIDTH: registered operand 1 to adder
- `add_vector_2` out DATA_WIDTH: registered operand 2 to adder
- `add_input_valid` out 1: one-cycle issue strobe to adder
- `add_output_valid` in 1: adder result strobe (lane-0 valid)
- `add_vector` in DATA_WIDTH: adder result data
- `out_valid` out 1 / `out_ready` in 1 / `out_data` out DATA_WIDTH: result stream
- `busy` out 1: high while any FIFO is non-empty or any credit is outstanding

## Operation
- Input FIFOs: `a_ready = !a_full`, `b_ready = !b_full`. Push occurs on `valid && ready`. The A and B streams are independent; pairing is strictly in arrival order per stream.
- Issue condition (cycle t): `!a_empty && !b_empty && credits != 0`. At the t edge, both heads pop into `add_vector_1`/`add_vector_2`, `add_input_valid` is 1 during t+1, and `credits` decrements.
- `add_input_valid` is 0 on every non-issue cycle. The operand registers hold their last value when not issuing.
- `credits` (width log2(OUT_DEPTH)+1) resets to OUT_DEPTH.
  - It decrements on issue and increments on an output handshake (`out_valid && out_ready`).
  - When both occur in the same cycle, it is unchanged.
  - It never exceeds OUT_DEPTH and never underflows.
- Result FIFO: a push occurs on every `add_output_valid` cycle while `rst` is low. The credit scheme guarantees it is never full at a push. An overflow attempt is a design error; the bench asserts on it.
- Output is first-word fall-through: `out_valid = !out_empty`, and `out_data` is the head entry, stable while `out_valid && !out_ready`.
- Pointer wrap: all FIFOs use a read/write pointer pair with one extra MSB; full means the MSBs differ and the rest are equal.
- `busy = !a_empty || !b_empty || !out_empty || credits != OUT_DEPTH`.

## Timing
- Reset values: `a_ready=0`, `b_ready=0` during `rst`; both are 1 on the first cycle after `rst` falls.
  - `add_input_valid=0`, `add_vector_1=0`, `add_vector_2=0`, `out_valid=0`, `busy=0`.
  - All FIFOs are empty and `credits=OUT_DEPTH`.
- Ingress to issue: data accepted at edge t can issue at edge t+1. `add_input_valid` is then high in cycle t+2.
- Sustained throughput is one pair per cycle while both streams are supplied and `out_ready=1`.
- Result to egress: `add_output_valid` at edge t gives `out_valid=1` in cycle t+1.
- Reset mid-operation:
  - `add_output_valid` is ignored while `rst=1`.
  - `rst` must be held for at least the adder latency + 1 cycles, so that stale adder results drain.
  - Operands already inside the adder are discarded.

## Configuration
- `VECTOR_ADD_ISSUE_STATS_EN` defined: adds outputs `stat_issued` (out, 32) and `stat_stall` (out, 32). Both reset to 0 and wrap at 2^32.
  - `stat_issued` increments on every issue.
  - `stat_stall` increments on every cycle where both input FIFOs are non-empty but `credits==0`.
- Undefined: both ports and their counters are absent. All other behaviour is identical.

## Test plan
- Single pair: A=all lanes 1.0 (0x3F800000), B=all lanes 2.0 → exactly one `add_input_valid` pulse, 2 cycles after the pair is accepted. `out_data` = all lanes 3.0 (0x40400000), and `busy` falls after the handshake.
- Skewed arrival: push 3 A vectors, then 3 B vectors 10 cycles later → no issue until the first B arrives. Results come out in order (A0+B0, A1+B1, A2+B2).
- Backpressure: `out_ready=0` with 20 pairs offered → exactly OUT_DEPTH=16 issues, then `a_ready`/`b_ready` fall once the input FIFOs fill. After `out_ready=1`, all 20 results drain in order with no overflow assertion.
- Full throughput: 64 pairs with `out_ready=1` and valids held high → 64 consecutive `add_input_valid` cycles, and credits never reach 0.
- Simultaneous events: an issue and an output handshake in the same cycle leave `credits` unchanged. With `a_full` asserted, `a_ready=0` and a held `a_data` is not lost.
- Reset mid-stream: assert `rst` for 16 cycles with 5 pairs in flight → no `out_valid` afterwards from stale results. `credits=16`, and a fresh pair returns the correct sum. With the macro defined, `stat_issued` counts only post-reset issues.

Source files
------------

// File: rtl/vector_add_issue.sv
// Operand pairing and issue stage feeding the fixed-latency vector_add unit.
// Define VECTOR_ADD_ISSUE_STATS_EN to add the stat_issued/stat_stall counters.
module vector_add_issue #(
   parameter int DATA_WIDTH = 512,
   parameter int IN_DEPTH   = 4,
   parameter int OUT_DEPTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic [DATA_WIDTH-1:0] a_data,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic [DATA_WIDTH-1:0] add_vector_1,
   output logic [DATA_WIDTH-1:0] add_vector_2,
   output logic                  add_input_valid,
   input  logic                  add_output_valid,
   input  logic [DATA_WIDTH-1:0] add_vector,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy
`ifdef VECTOR_ADD_ISSUE_STATS_EN
   ,
   output logic [31:0]           stat_issued,
   output logic [31:0]           stat_stall
`endif
);

   localparam int IAW = $clog2(IN_DEPTH);
   localparam int OAW = $clog2(OUT_DEPTH);
   localparam int CW  = OAW + 1;
   localparam logic [CW-1:0] CREDIT_MAX = CW'(OUT_DEPTH);
   localparam logic [CW-1:0] CONE = 1;
   localparam logic [IAW:0]  IONE = 1;
   localparam logic [OAW:0]  OONE = 1;

   logic [DATA_WIDTH-1:0] a_mem [IN_DEPTH];
   logic [DATA_WIDTH-1:0] b_mem [IN_DEPTH];
   logic [DATA_WIDTH-1:0] o_mem [OUT_DEPTH];

   logic [IAW:0] a_wr, a_rd, b_wr, b_rd;
   logic [OAW:0] o_wr, o_rd;
   logic [CW-1:0] credits;

   logic a_empty, a_full, a_push;
   logic b_empty, b_full, b_push;
   logic o_empty, o_push;
   logic issue, out_fire;

   // Extra pointer MSB distinguishes full from empty.
   assign a_empty = (a_wr == a_rd);
   assign a_full  = (a_wr[IAW] != a_rd[IAW]) &&
                    (a_wr[IAW-1:0] == a_rd[IAW-1:0]);
   assign b_empty = (b_wr == b_rd);
   assign b_full  = (b_wr[IAW] != b_rd[IAW]) &&
                    (b_wr[IAW-1:0] == b_rd[IAW-1:0]);
   assign o_empty = (o_wr == o_rd);

   assign a_ready = !rst && !a_full;
   assign b_ready = !rst && !b_full;
   assign a_push  = a_valid && a_ready;
   assign b_push  = b_valid && b_ready;

   assign issue    = !a_empty && !b_empty && (credits != '0);
   assign o_push   = add_output_valid && !rst;
   assign out_valid = !o_empty;
   assign out_data  = o_mem[o_rd[OAW-1:0]];
   assign out_fire  = out_valid && out_ready;

   assign busy = !a_empty || !b_empty || !o_empty ||
                 (credits != CREDIT_MAX);

   always_ff @(posedge clk) begin
      if (a_push) a_mem[a_wr[IAW-1:0]] <= a_data;
      if (b_push) b_mem[b_wr[IAW-1:0]] <= b_data;
      if (o_push) o_mem[o_wr[OAW-1:0]] <= add_vector;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_wr <= '0;
         a_rd <= '0;
         b_wr <= '0;
         b_rd <= '0;
         o_wr <= '0;
         o_rd <= '0;
      end else begin
         if (a_push) a_wr <= a_wr + IONE;
         if (b_push) b_wr <= b_wr + IONE;
         if (issue) begin
            a_rd <= a_rd + IONE;
            b_rd <= b_rd + IONE;
         end
         if (o_push) o_wr <= o_wr + OONE;
         if (out_fire) o_rd <= o_rd + OONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         add_input_valid <= 1'b0;
         add_vector_1    <= '0;
         add_vector_2    <= '0;
      end else begin
         add_input_valid <= issue;
         if (issue) begin
            add_vector_1 <= a_mem[a_rd[IAW-1:0]];
            add_vector_2 <= b_mem[b_rd[IAW-1:0]];
         end
      end
   end

   // One credit per free result slot; issue and drain together cancel.
   always_ff @(posedge clk) begin
      if (rst) begin
         credits <= CREDIT_MAX;
      end else begin
         unique case ({issue, out_fire})
            2'b10:   credits <= credits - CONE;
            2'b01:   credits <= credits + CONE;
            default: credits <= credits;
         endcase
      end
   end

`ifdef VECTOR_ADD_ISSUE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_issued <= '0;
         stat_stall  <= '0;
      end else begin
         if (issue) stat_issued <= stat_issued + 32'd1;
         if (!a_empty && !b_empty && (credits == '0))
            stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vector_add_issue.sv
// Randomized self-checking bench for vector_add_issue with a
// behavioural fixed-latency fp32 adder and an integer-sum reference model.
module tb_vector_add_issue;

   localparam int DW    = 512;
   localparam int IND   = 4;
   localparam int OUTD  = 16;
   localparam int LANES = 16;
   localparam int LAT   = 4;

   typedef logic [DW-1:0] vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a_valid, a_ready, b_valid, b_ready;
   vec_t a_data, b_data;
   vec_t add_vector_1, add_vector_2, add_vector, out_data;
   logic add_input_valid, add_output_valid;
   logic out_valid, out_ready, busy;
`ifdef VECTOR_ADD_ISSUE_STATS_EN
   logic [31:0] stat_issued, stat_stall;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int issue_cnt = 0;
   int run = 0;
   int max_run = 0;
   int last_iv = 0;
   int last_a_acc = 0;
   int last_b_acc = 0;
   int occ = 0;

   vec_t a_src[$];
   vec_t b_src[$];
   vec_t got_q[$];
   vec_t exp_q[$];

   always #5 clk = ~clk;

   vector_add_issue #(
      .DATA_WIDTH(DW),
      .IN_DEPTH(IND),
      .OUT_DEPTH(OUTD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .a_valid(a_valid),
      .a_ready(a_ready),
      .a_data(a_data),
      .b_valid(b_valid),
      .b_ready(b_ready),
      .b_data(b_data),
      .add_vector_1(add_vector_1),
      .add_vector_2(add_vector_2),
      .add_input_valid(add_input_valid),
      .add_output_valid(add_output_valid),
      .add_vector(add_vector),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .busy(busy)
`ifdef VECTOR_ADD_ISSUE_STATS_EN
      ,
      .stat_issued(stat_issued),
      .stat_stall(stat_stall)
`endif
   );

   function automatic real f2r(input logic [31:0] f);
      logic [10:0] e;
      if (f[30:0] == 31'd0) return 0.0;
      e = {3'b000, f[30:23]} + 11'd896;
      return $bitstoreal({f[31], e, f[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] b;
      logic [10:0] e;
      if (r == 0.0) return 32'd0;
      b = $realtobits(r);
      e = b[62:52] - 11'd896;
      return {b[63], e[7:0], b[51:29]};
   endfunction

   function automatic vec_t fadd(input vec_t x, input vec_t y);
      vec_t s;
      for (int l = 0; l < LANES; l++)
         s[l*32 +: 32] = r2f(f2r(x[l*32 +: 32]) + f2r(y[l*32 +: 32]));
      return s;
   endfunction

   // Behavioural adder: fixed latency, no reset, no backpressure.
   logic [LAT-1:0] vp = '0;
   vec_t dp [LAT];
   always @(posedge clk) begin
      vp <= {vp[LAT-2:0], add_input_valid};
      dp[0] <= fadd(add_vector_1, add_vector_2);
      for (int i = 1; i < LAT; i++) dp[i] <= dp[i-1];
   end
   assign add_output_valid = vp[LAT-1];
   assign add_vector = dp[LAT-1];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      bit fire;
      a_valid = 1'b0;
      a_data = '0;
      forever begin
         @(negedge clk);
         fire = a_valid && a_ready;
         @(posedge clk);
         #1;
         if (fire) void'(a_src.pop_front());
         a_valid = (a_src.size() > 0);
         if (a_valid) a_data = a_src[0];
      end
   end

   initial begin
      bit fire;
      b_valid = 1'b0;
      b_data = '0;
      forever begin
         @(negedge clk);
         fire = b_valid && b_ready;
         @(posedge clk);
         #1;
         if (fire) void'(b_src.pop_front());
         b_valid = (b_src.size() > 0);
         if (b_valid) b_data = b_src[0];
      end
   end

   // Observe issues, acceptances, results and result-FIFO occupancy.
   initial forever begin
      @(negedge clk);
      if (add_input_valid) begin
         issue_cnt++;
         run++;
         last_iv = cyc;
         if (run > max_run) max_run = run;
      end else begin
         run = 0;
      end
      if (a_valid && a_ready) last_a_acc = cyc + 1;
      if (b_valid && b_ready) last_b_acc = cyc + 1;
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (rst) begin
         occ = 0;
      end else begin
         if (add_output_valid) begin
            checks++;
            if (occ >= OUTD) begin
               errors++;
               $display("FAIL overflow: occupancy %0d at push, limit %0d",
                        occ, OUTD - 1);
            end
         end
         occ = occ + int'(add_output_valid) - int'(out_valid && out_ready);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic gen_pair(output vec_t a, output vec_t b, output vec_t s);
      int unsigned x, y;
      a = '0;
      b = '0;
      s = '0;
      for (int l = 0; l < LANES; l++) begin
         x = $urandom_range(65535);
         y = $urandom_range(65535);
         a[l*32 +: 32] = r2f(real'(x));
         b[l*32 +: 32] = r2f(real'(y));
         s[l*32 +: 32] = r2f(real'(x + y));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      out_ready = 1'b0;
      step(3);
      checks += 7;
      if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready: got %b want 0", a_ready); end
      if (b_ready !== 1'b0) begin errors++; $display("FAIL rst_b_ready: got %b want 0", b_ready); end
      if (add_input_valid !== 1'b0) begin errors++; $display("FAIL rst_aiv: got %b want 0", add_input_valid); end
      if (add_vector_1 !== '0) begin errors++; $display("FAIL rst_v1: got %h want 0", add_vector_1); end
      if (add_vector_2 !== '0) begin errors++; $display("FAIL rst_v2: got %h want 0", add_vector_2); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
`ifdef VECTOR_ADD_ISSUE_STATS_EN
      checks += 2;
      if (stat_issued !== 32'd0) begin errors++; $display("FAIL rst_stat_issued: got %0d want 0", stat_issued); end
      if (stat_stall !== 32'd0) begin errors++; $display("FAIL rst_stat_stall: got %0d want 0", stat_stall); end
`endif
      rst = 1'b0;
      #1;
      checks += 2;
      if (a_ready !== 1'b1) begin errors++; $display("FAIL post_rst_a_ready: got %b want 1", a_ready); end
      if (b_ready !== 1'b1) begin errors++; $display("FAIL post_rst_b_ready: got %b want 1", b_ready); end
      step(1);
   endtask

   task automatic test_single_pair();
      int base;
      vec_t g;
      vec_t want;
      vec_t one;
      vec_t two;
      one = {LANES{32'h3F800000}};
      two = {LANES{32'h40000000}};
      want = {LANES{32'h40400000}};
      out_ready = 1'b1;
      got_q.delete();
      base = issue_cnt;
      a_src.push_back(one);
      b_src.push_back(two);
      step(2);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_high: got %b want 1", busy); end
      for (int k = 0; k < 100 && got_q.size() < 1; k++) step(1);
      step(2);
      g = (got_q.size() > 0) ? got_q[0] : '0;
      checks += 5;
      if (got_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
      if (issue_cnt - base != 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", issue_cnt - base); end
      // Accepted at edge t -> issued at edge t+1 -> strobe high the cycle after.
      if (last_iv != ((last_a_acc > last_b_acc) ? last_a_acc : last_b_acc) + 1) begin
         errors++;
         $display("FAIL single_latency: issue edge %0d, accept edges %0d/%0d, want accept+1",
                  last_iv, last_a_acc, last_b_acc);
      end
      if (g !== want) begin errors++; $display("FAIL single_data: got %h want %h", g, want); end
      if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_low: got %b want 0", busy); end
   endtask

   task automatic test_skewed();
      int base;
      vec_t a, b, s, g;
      vec_t bq[$];
      out_ready = 1'b1;
      got_q.delete();
      exp_q.delete();
      base = issue_cnt;
      for (int i = 0; i < 3; i++) begin
         gen_pair(a, b, s);
         a_src.push_back(a);
         bq.push_back(b);
         exp_q.push_back(s);
      end
      step(10);
      checks++;
      if (issue_cnt != base) begin errors++; $display("FAIL skew_early_issue: got %0d want 0", issue_cnt - base); end
      foreach (bq[i]) b_src.push_back(bq[i]);
      for (int k = 0; k < 200 && got_q.size() < 3; k++) step(1);
      step(2);
      checks += 2;
      if (issue_cnt - base != 3) begin errors++; $display("FAIL skew_issues: got %0d want 3", issue_cnt - base); end
      if (busy !== 1'b0) begin errors++; $display("FAIL skew_busy: got %b want 0", busy); end
      for (int i = 0; i < 3; i++) begin
         g = (i < got_q.size()) ? got_q[i] : '0;
         checks++;
         if (g !== exp_q[i]) begin errors++; $display("FAIL skew_data[%0d]: got %h want %h", i, g, exp_q[i]); end
      end
   endtask

   task automatic test_backpressure();
      int base;
      vec_t a, b, s, g;
      out_ready = 1'b0;
      got_q.delete();
      exp_q.delete();
      base = issue_cnt;
      for (int i = 0; i < 20; i++) begin
         gen_pair(a, b, s);
         a_src.push_back(a);
         b_src.push_back(b);
         exp_q.push_back(s);
      end
      step(60);
      checks += 4;
      if (issue_cnt - base != OUTD) begin errors++; $display("FAIL bp_issues: got %0d want %0d", issue_cnt - base, OUTD); end
      if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_a_ready: got %b want 0", a_ready); end
      if (b_ready !== 1'b0) begin errors++; $display("FAIL bp_b_ready: got %b want 0", b_ready); end
      if (a_src.size() + b_src.size() != 0) begin
         errors++;
         $display("FAIL bp_accepted: pending %0d/%0d want 0/0", a_src.size(), b_src.size());
      end
      out_ready = 1'b1;
      for (int k = 0; k < 300 && got_q.size() < 20; k++) step(1);
      step(2);
      checks += 3;
      if (got_q.size() != 20) begin errors++; $display("FAIL bp_count: got %0d want 20", got_q.size()); end
      if (issue_cnt - base != 20) begin errors++; $display("FAIL bp_total: got %0d want 20", issue_cnt - base); end
      if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy: got %b want 0", busy); end
      for (int i = 0; i < 20; i++) begin
         g = (i < got_q.size()) ? got_q[i] : '0;
         checks++;
         if (g !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, g, exp_q[i]); end
      end
   endtask

   task automatic test_full_throughput();
      int base;
      vec_t a, b, s, g;
      out_ready = 1'b1;
      got_q.delete();
      exp_q.delete();
      base = issue_cnt;
      max_run = 0;
      for (int i = 0; i < 64; i++) begin
         gen_pair(a, b, s);
         a_src.push_back(a);
         b_src.push_back(b);
         exp_q.push_back(s);
      end
      for (int k = 0; k < 400 && got_q.size() < 64; k++) step(1);
      step(2);
      checks += 4;
      if (got_q.size() != 64) begin errors++; $display("FAIL tput_count: got %0d want 64", got_q.size()); end
      if (issue_cnt - base != 64) begin errors++; $display("FAIL tput_issues: got %0d want 64", issue_cnt - base); end
      if (max_run != 64) begin errors++; $display("FAIL tput_run: got %0d want 64", max_run); end
      if (busy !== 1'b0) begin errors++; $display("FAIL tput_busy: got %b want 0", busy); end
      for (int i = 0; i < 64; i++) begin
         g = (i < got_q.size()) ? got_q[i] : '0;
         checks++;
         if (g !== exp_q[i]) begin errors++; $display("FAIL tput_data[%0d]: got %h want %h", i, g, exp_q[i]); end
      end
   endtask

   task automatic test_simultaneous();
      int base;
      vec_t a, b, s, g;
      out_ready = 1'b0;
      got_q.delete();
      exp_q.delete();
      base = issue_cnt;
      for (int i = 0; i < 22; i++) begin
         gen_pair(a, b, s);
         a_src.push_back(a);
         b_src.push_back(b);
         exp_q.push_back(s);
      end
      step(60);
      checks += 3;
      if (issue_cnt - base != OUTD) begin errors++; $display("FAIL sim_issues: got %0d want %0d", issue_cnt - base, OUTD); end
      if (a_ready !== 1'b0) begin errors++; $display("FAIL sim_a_ready: got %b want 0", a_ready); end
      if (a_src.size() != 2 || b_src.size() != 2) begin
         errors++;
         $display("FAIL sim_held: pending %0d/%0d want 2/2", a_src.size(), b_src.size());
      end
      // Two handshakes: the first frees a credit, the second coincides with its use.
      out_ready = 1'b1;
      step(2);
      out_ready = 1'b0;
      step(20);
      checks++;
      if (issue_cnt - base != OUTD + 2) begin
         errors++;
         $display("FAIL sim_credit: got %0d want %0d", issue_cnt - base, OUTD + 2);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 300 && got_q.size() < 22; k++) step(1);
      step(2);
      checks += 3;
      if (got_q.size() != 22) begin errors++; $display("FAIL sim_count: got %0d want 22", got_q.size()); end
      if (issue_cnt - base != 22) begin errors++; $display("FAIL sim_total: got %0d want 22", issue_cnt - base); end
      if (busy !== 1'b0) begin errors++; $display("FAIL sim_busy: got %b want 0", busy); end
      for (int i = 0; i < 22; i++) begin
         g = (i < got_q.size()) ? got_q[i] : '0;
         checks++;
         if (g !== exp_q[i]) begin errors++; $display("FAIL sim_data[%0d]: got %h want %h", i, g, exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid();
      int k;
      int seen;
      vec_t a, b, s, g;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         gen_pair(a, b, s);
         a_src.push_back(a);
         b_src.push_back(b);
      end
      for (k = 0; k < 50 && (a_src.size() + b_src.size()) != 0; k++) step(1);
      checks++;
      if (k >= 50) begin errors++; $display("FAIL mid_accept: pending %0d want 0", a_src.size() + b_src.size()); end
      step(2);
      rst = 1'b1;
      step(16);
      rst = 1'b0;
      #1;
      got_q.delete();
      exp_q.delete();
`ifdef VECTOR_ADD_ISSUE_STATS_EN
      checks++;
      if (stat_issued !== 32'd0) begin errors++; $display("FAIL mid_stat_clear: got %0d want 0", stat_issued); end
`endif
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (out_valid) seen++;
      end
      checks += 3;
      if (seen != 0) begin errors++; $display("FAIL mid_stale: got %0d valid cycles want 0", seen); end
      if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
      if (a_ready !== 1'b1) begin errors++; $display("FAIL mid_a_ready: got %b want 1", a_ready); end
      out_ready = 1'b1;
      gen_pair(a, b, s);
      a_src.push_back(a);
      b_src.push_back(b);
      exp_q.push_back(s);
      for (int j = 0; j < 100 && got_q.size() < 1; j++) step(1);
      step(2);
      g = (got_q.size() > 0) ? got_q[0] : '0;
      checks += 3;
      if (got_q.size() != 1) begin errors++; $display("FAIL mid_count: got %0d want 1", got_q.size()); end
      if (g !== exp_q[0]) begin errors++; $display("FAIL mid_data: got %h want %h", g, exp_q[0]); end
      if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_end: got %b want 0", busy); end
`ifdef VECTOR_ADD_ISSUE_STATS_EN
      checks++;
      if (stat_issued !== 32'd1) begin errors++; $display("FAIL mid_stat_issued: got %0d want 1", stat_issued); end
`endif
   endtask

   initial begin
      out_ready = 1'b0;
      test_reset();
      test_single_pair();
      test_skewed();
      test_backpressure();
      test_full_throughput();
      test_simultaneous();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
